// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory arbiter slice.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        CAPTURE,
        ERR
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } port_t;

    // A word address is legal when aligned and the whole word lies inside the RAM.
    function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                     input logic [WORD_W-1:0] limit);
        return (addr[1:0] == 2'b00) && (addr <= limit - 32'd4);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response ports of both requesters plus the RAM-side bus.
interface mem_arbiter_if;
    import mem_pkg::*;

    logic              IfReqValid;
    logic              IfReqReady;
    logic [WORD_W-1:0] IfReqAddr;
    logic              IfRspValid;
    logic [WORD_W-1:0] IfRspData;
    logic              IfRspErr;

    logic              DReqValid;
    logic              DReqReady;
    logic [WORD_W-1:0] DReqAddr;
    logic              DReqWrite;
    logic [WORD_W-1:0] DReqWData;
    logic              DRspValid;
    logic [WORD_W-1:0] DRspData;
    logic              DRspErr;

    logic [WORD_W-1:0] RamAddress;
    logic              RamWriteEnable;
    logic [WORD_W-1:0] RamWriteValue;
    logic [WORD_W-1:0] RamReadValue;

    // Arbiter side.
    modport slave (
        input  IfReqValid, IfReqAddr,
        input  DReqValid, DReqAddr, DReqWrite, DReqWData,
        input  RamReadValue,
        output IfReqReady, IfRspValid, IfRspData, IfRspErr,
        output DReqReady, DRspValid, DRspData, DRspErr,
        output RamAddress, RamWriteEnable, RamWriteValue
    );

    // Requester / RAM side.
    modport master (
        output IfReqValid, IfReqAddr,
        output DReqValid, DReqAddr, DReqWrite, DReqWData,
        output RamReadValue,
        input  IfReqReady, IfRspValid, IfRspData, IfRspErr,
        input  DReqReady, DRspValid, DRspData, DRspErr,
        input  RamAddress, RamWriteEnable, RamWriteValue
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; the grant doubles as the Ready of each port.
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_fetch,
    input  logic req_data,
    output logic gnt_fetch,
    output logic gnt_data
);

    port_t last_grant_reg;

    // Grant the sole requester, or the one not served last when both ask.
    always_comb begin
        gnt_fetch = 1'b0;
        gnt_data  = 1'b0;
        if (enable) begin
            if (req_fetch && req_data) begin
                if (last_grant_reg == DATA) begin
                    gnt_fetch = 1'b1;
                end else begin
                    gnt_data = 1'b1;
                end
            end else begin
                gnt_fetch = req_fetch;
                gnt_data  = req_data;
            end
        end
    end

    // A grant only exists with Valid high, so every grant is an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= DATA;
        end else if (gnt_fetch) begin
            last_grant_reg <= FETCH;
        end else if (gnt_data) begin
            last_grant_reg <= DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter serialising requests onto a one-cycle-latency RAM.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int INIT_WAIT  = 2,
    parameter int ADDR_LIMIT = 65536
)
(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    state_t            state_reg, state_next;
    logic [31:0]       init_cnt_reg;
    port_t             port_reg;
    logic              write_reg;

    logic              gnt_fetch, gnt_data;
    logic              accept;
    logic              acc_ok;
    logic [WORD_W-1:0] acc_addr;

    logic              if_rsp_valid_reg, if_rsp_err_reg;
    logic [WORD_W-1:0] if_rsp_data_reg;
    logic              d_rsp_valid_reg, d_rsp_err_reg;
    logic [WORD_W-1:0] d_rsp_data_reg;
    logic [WORD_W-1:0] ram_addr_reg, ram_wval_reg;
    logic              ram_we_reg;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_reg == IDLE),
        .req_fetch (bus.IfReqValid),
        .req_data  (bus.DReqValid),
        .gnt_fetch (gnt_fetch),
        .gnt_data  (gnt_data)
    );

    assign bus.IfReqReady     = gnt_fetch;
    assign bus.DReqReady      = gnt_data;
    assign bus.IfRspValid     = if_rsp_valid_reg;
    assign bus.IfRspErr       = if_rsp_err_reg;
    assign bus.IfRspData      = if_rsp_data_reg;
    assign bus.DRspValid      = d_rsp_valid_reg;
    assign bus.DRspErr        = d_rsp_err_reg;
    assign bus.DRspData       = d_rsp_data_reg;
    assign bus.RamAddress     = ram_addr_reg;
    assign bus.RamWriteEnable = ram_we_reg;
    assign bus.RamWriteValue  = ram_wval_reg;

    assign accept   = gnt_fetch || gnt_data;
    assign acc_addr = gnt_data ? bus.DReqAddr : bus.IfReqAddr;
    assign acc_ok   = addr_ok(acc_addr, 32'(ADDR_LIMIT));

    // Next-state: hold off during image load, then one transaction at a time.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT: begin
                if (INIT_WAIT == 0 || init_cnt_reg == 32'(INIT_WAIT - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (accept) begin
                    state_next = acc_ok ? ISSUE : ERR;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    // State register and image-load wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == INIT) begin
                init_cnt_reg <= init_cnt_reg + 32'd1;
            end
        end
    end

    // RAM drive on legal accepts, transaction bookkeeping and response strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_reg     <= '0;
            ram_we_reg       <= 1'b0;
            ram_wval_reg     <= '0;
            port_reg         <= FETCH;
            write_reg        <= 1'b0;
            if_rsp_valid_reg <= 1'b0;
            if_rsp_err_reg   <= 1'b0;
            if_rsp_data_reg  <= '0;
            d_rsp_valid_reg  <= 1'b0;
            d_rsp_err_reg    <= 1'b0;
            d_rsp_data_reg   <= '0;
        end else begin
            if_rsp_valid_reg <= 1'b0;
            if_rsp_err_reg   <= 1'b0;
            d_rsp_valid_reg  <= 1'b0;
            d_rsp_err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        port_reg  <= gnt_data ? DATA : FETCH;
                        write_reg <= gnt_data && bus.DReqWrite;
                        if (acc_ok) begin
                            ram_addr_reg <= acc_addr;
                            ram_we_reg   <= gnt_data && bus.DReqWrite;
                            ram_wval_reg <= gnt_data ? bus.DReqWData : '0;
                        end
                    end
                end
                ISSUE: begin
                    ram_we_reg <= 1'b0;
                end
                CAPTURE: begin
                    if (port_reg == DATA) begin
                        d_rsp_valid_reg <= 1'b1;
                        d_rsp_data_reg  <= write_reg ? '0 : bus.RamReadValue;
                    end else begin
                        if_rsp_valid_reg <= 1'b1;
                        if_rsp_data_reg  <= bus.RamReadValue;
                    end
                end
                ERR: begin
                    if (port_reg == DATA) begin
                        d_rsp_valid_reg <= 1'b1;
                        d_rsp_err_reg   <= 1'b1;
                        d_rsp_data_reg  <= '0;
                    end else begin
                        if_rsp_valid_reg <= 1'b1;
                        if_rsp_err_reg   <= 1'b1;
                        if_rsp_data_reg  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_arbiter;
    import mem_pkg::*;

    typedef struct {
        logic        is_data;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.INIT_WAIT(2), .ADDR_LIMIT(65536)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    // RAM model: preloaded image, write on WriteEnable, registered read.
    logic [31:0] ram [0:16383];
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = {16'hC0DE, 16'(i)};
        bus.RamReadValue = '0;
        forever begin
            @(posedge clk);
            if (bus.RamWriteEnable) ram[bus.RamAddress[15:2]] <= bus.RamWriteValue;
            bus.RamReadValue <= ram[bus.RamAddress[15:2]];
        end
    end

    // Activity counters sampled on the falling edge.
    int          we_cnt = 0;
    int          if_rsp_cnt = 0;
    int          d_rsp_cnt = 0;
    logic [31:0] last_we_addr = '0;
    always @(negedge clk) begin
        if (bus.RamWriteEnable) begin
            we_cnt++;
            last_we_addr = bus.RamAddress;
        end
        if (bus.IfRspValid) if_rsp_cnt++;
        if (bus.DRspValid) d_rsp_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drop_all();
        bus.IfReqValid = 1'b0;
        bus.DReqValid  = 1'b0;
        bus.DReqWrite  = 1'b0;
    endtask

    // One isolated transaction: wait for Ready, then check latency, payload and RAM activity.
    task automatic do_txn(input vec_t v, input int idx);
        int   lat;
        logic got;
        int   we0, ifc0, dc0;
        logic [31:0] rd;
        logic er, other;
        @(posedge clk); #1;
        we0 = we_cnt; ifc0 = if_rsp_cnt; dc0 = d_rsp_cnt;
        if (v.is_data) begin
            bus.DReqValid = 1'b1; bus.DReqAddr = v.addr;
            bus.DReqWrite = v.write; bus.DReqWData = v.wdata;
        end else begin
            bus.IfReqValid = 1'b1; bus.IfReqAddr = v.addr;
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = v.is_data ? bus.DReqReady : bus.IfReqReady;
        end
        chk("txn_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        drop_all();
        got = 1'b0; lat = 0;
        for (int c = 0; c < 5 && !got; c++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            got = v.is_data ? bus.DRspValid : bus.IfRspValid;
        end
        rd    = v.is_data ? bus.DRspData : bus.IfRspData;
        er    = v.is_data ? bus.DRspErr : bus.IfRspErr;
        other = v.is_data ? bus.IfRspValid : bus.DRspValid;
        chk("txn_rsp_valid", 32'(got), 32'd1);
        chk("txn_latency", 32'(lat), v.exp_err ? 32'd1 : 32'd2);
        chk("txn_err", 32'(er), 32'(v.exp_err));
        chk("txn_rdata", rd, v.exp_rdata);
        chk("txn_other_port_quiet", 32'(other), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("txn_rsp_one_cycle", 32'(v.is_data ? bus.DRspValid : bus.IfRspValid), 32'd0);
        chk("txn_we_pulses", 32'(we_cnt - we0),
            (v.is_data && v.write && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.is_data && v.write && !v.exp_err) chk("txn_we_addr", last_we_addr, v.addr);
        chk("txn_if_rsp_count", 32'(if_rsp_cnt - ifc0), v.is_data ? 32'd0 : 32'd1);
        chk("txn_d_rsp_count", 32'(d_rsp_cnt - dc0), v.is_data ? 32'd1 : 32'd0);
        $display("txn %0d: %s %s addr=%h wdata=%h -> err=%0d rdata=%h latency=%0d",
                 idx, v.is_data ? "data" : "fetch", v.write ? "wr" : "rd",
                 v.addr, v.wdata, er, rd, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [10];
    vec_t rd_vec;
    int   n_acc, n_rsp, cyc, last_acc, ifc0, we0;
    port_t pend;
    logic [31:0] ra0;
    logic  got_r;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0000_0000, 1'b0, 32'hC0DE_3FFF};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_FFFC, 32'h1234_5678, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[9] = '{1'b1, 1'b1, 32'h0001_0000, 32'h5555_AAAA, 1'b1, 32'h0000_0000};

        // Reset with a fetch already pending.
        drop_all();
        bus.IfReqAddr = '0; bus.DReqAddr = '0; bus.DReqWData = '0;
        bus.IfReqValid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", 32'(bus.IfReqReady), 32'd0);
        chk("rst_d_ready", 32'(bus.DReqReady), 32'd0);
        chk("rst_rsp_valid", 32'({bus.IfRspValid, bus.DRspValid}), 32'd0);
        chk("rst_rsp_err", 32'({bus.IfRspErr, bus.DRspErr}), 32'd0);
        chk("rst_if_data", bus.IfRspData, 32'd0);
        chk("rst_d_data", bus.DRspData, 32'd0);
        chk("rst_ram_addr", bus.RamAddress, 32'd0);
        chk("rst_ram_we", 32'(bus.RamWriteEnable), 32'd0);
        chk("rst_ram_wval", bus.RamWriteValue, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("init_cycle1_ready", 32'(bus.IfReqReady), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("init_cycle2_ready", 32'(bus.IfReqReady), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("idle_first_ready", 32'(bus.IfReqReady), 32'd1);
        $display("init: IfReqReady rose in first IDLE cycle");
        drop_all();
        ifc0 = if_rsp_cnt;
        repeat (4) @(posedge clk);
        #1 chk("withdrawn_no_rsp", 32'(if_rsp_cnt - ifc0), 32'd0);

        // Table-driven single transactions.
        for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

        // Both requesters held valid: strict alternation, one accept per 3 cycles.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bus.IfReqValid = 1'b1; bus.IfReqAddr = 32'h200;
        bus.DReqValid = 1'b1; bus.DReqAddr = 32'h204; bus.DReqWrite = 1'b0;
        n_acc = 0; n_rsp = 0; cyc = 0; last_acc = 0; pend = FETCH;
        for (int c = 0; c < 40 && (n_acc < 4 || n_rsp < 4); c++) begin
            @(negedge clk); cyc++;
            if (bus.IfRspValid || bus.DRspValid) begin
                chk("both_rsp_port", 32'({bus.IfRspValid, bus.DRspValid}),
                    (pend == DATA) ? 32'd1 : 32'd2);
                if (pend == DATA) chk("both_d_rdata", bus.DRspData, 32'hC0DE_0081);
                else chk("both_if_rdata", bus.IfRspData, 32'hC0DE_0080);
                $display("both: response %0d on %s", n_rsp, (pend == DATA) ? "data" : "fetch");
                n_rsp++;
            end
            if ((bus.IfReqReady || bus.DReqReady) && n_acc < 4) begin
                chk("both_grant", 32'({bus.IfReqReady, bus.DReqReady}),
                    (n_acc % 2 == 1) ? 32'd1 : 32'd2);
                if (n_acc > 0) chk("both_spacing", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                pend = bus.DReqReady ? DATA : FETCH;
                $display("both: accept %0d granted %s at cycle %0d", n_acc,
                         bus.DReqReady ? "data" : "fetch", cyc);
                n_acc++;
                if (n_acc == 4) begin
                    @(posedge clk); #1;
                    drop_all();
                end
            end
        end
        chk("both_accepts", 32'(n_acc), 32'd4);
        chk("both_responses", 32'(n_rsp), 32'd4);

        // Reset during CAPTURE of a fetch read.
        repeat (2) @(posedge clk);
        #1 bus.IfReqValid = 1'b1; bus.IfReqAddr = 32'h100;
        ifc0 = if_rsp_cnt;
        got_r = 1'b0;
        for (int c = 0; c < 20 && !got_r; c++) begin
            @(negedge clk);
            got_r = bus.IfReqReady;
        end
        chk("midrst_accept", 32'(got_r), 32'd1);
        @(posedge clk); #1 bus.IfReqValid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bus.DReqValid = 1'b1; bus.DReqAddr = 32'h100; bus.DReqWrite = 1'b0;
        @(negedge clk);
        chk("midrst_no_if_rsp_c1", 32'(bus.IfRspValid), 32'd0);
        chk("midrst_ready_c1", 32'(bus.DReqReady), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("midrst_no_if_rsp_c2", 32'(bus.IfRspValid), 32'd0);
        chk("midrst_ready_c2", 32'(bus.DReqReady), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("midrst_ready_c3", 32'(bus.DReqReady), 32'd1);
        chk("midrst_if_rsp_count", 32'(if_rsp_cnt - ifc0), 32'd0);
        drop_all();
        $display("midrst: fetch dropped by reset, resuming service");
        rd_vec = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        do_txn(rd_vec, 10);

        // Fetch valid withdrawn while Ready is still low.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bus.IfReqValid = 1'b1; bus.IfReqAddr = 32'h40;
        ifc0 = if_rsp_cnt; we0 = we_cnt; ra0 = bus.RamAddress;
        @(negedge clk);
        chk("drop_ready_low", 32'(bus.IfReqReady), 32'd0);
        drop_all();
        repeat (6) @(posedge clk);
        #1;
        chk("drop_no_rsp", 32'(if_rsp_cnt - ifc0), 32'd0);
        chk("drop_ram_addr", bus.RamAddress, ra0);
        chk("drop_no_we", 32'(we_cnt - we0), 32'd0);
        $display("drop: withdrawn fetch produced no activity");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
